// File: rtl/four_bit_counter.sv
// rtl/four_bit_counter.sv - 4-bit up-counter with parallel load and async active-low clear
module four_bit_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       S,
   input  logic [3:0] D,
   output logic [3:0] qout
);

   logic [3:0] carry;
   logic [3:0] inc_sum;
   logic [3:0] next_q;

   // Ripple half-adder chain with carry-in tied high; the final carry-out is dropped (mod-16).
   assign carry[0]   = 1'b1;
   assign carry[3:1] = qout[2:0] & carry[2:0];

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_bit
         assign inc_sum[i] = qout[i] ^ carry[i];
         assign next_q[i]  = S ? D[i] : inc_sum[i];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         qout <= 4'h0;
      end else begin
         qout <= next_q;
      end
   end

endmodule

// File: tb/tb_four_bit_counter.sv
// tb/tb_four_bit_counter.sv - directed self-checking bench for four_bit_counter
module tb_four_bit_counter;

   logic       clk;
   logic       reset;
   logic       S;
   logic [3:0] D;
   logic [3:0] qout;

   int errors = 0;
   int checks = 0;

   four_bit_counter dut (
      .clk  (clk),
      .reset(reset),
      .S    (S),
      .D    (D),
      .qout (qout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] actual, input logic [3:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: qout=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Drive S/D on the falling edge, then sample just after the next rising edge.
   task automatic tick(input logic s, input logic [3:0] d, input logic [3:0] expected, input string tag);
      @(negedge clk);
      S = s;
      D = d;
      @(posedge clk);
      #1;
      check(tag, qout, expected);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      S     = 1'b1;
      D     = 4'h7;
      #1;
      check("por_immediate", qout, 4'h0);
      @(posedge clk); #1;
      check("por_edge1", qout, 4'h0);
      @(posedge clk); #1;
      check("por_edge2", qout, 4'h0);

      @(negedge clk);
      reset = 1'b1;
      tick(1'b1, 4'h7, 4'h7, "load_7");
      tick(1'b0, 4'h0, 4'h8, "count_8");
      tick(1'b0, 4'h3, 4'h9, "count_9");
      tick(1'b0, 4'hC, 4'hA, "count_a");

      tick(1'b1, 4'h4, 4'h4, "reload_4");
      tick(1'b0, 4'h4, 4'h5, "count_5");
      tick(1'b0, 4'h4, 4'h6, "count_6");
      tick(1'b0, 4'h4, 4'h7, "count_7");

      // Async clear between edges, held across two edges with load requested.
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async_clear", qout, 4'h0);
      S = 1'b1;
      D = 4'h9;
      @(posedge clk); #1;
      check("reset_hold1", qout, 4'h0);
      @(posedge clk); #1;
      check("reset_hold2", qout, 4'h0);
      @(negedge clk);
      S = 1'b0;
      reset = 1'b1;
      #1;
      check("release_nochange", qout, 4'h0);
      @(posedge clk); #1;
      check("release_count1", qout, 4'h1);

      tick(1'b1, 4'hE, 4'hE, "load_e");
      tick(1'b0, 4'h0, 4'hF, "count_f");
      tick(1'b0, 4'h0, 4'h0, "wrap_0");
      tick(1'b0, 4'h0, 4'h1, "wrap_1");

      // S/D changes between edges must not matter; only the rising-edge sample counts.
      @(negedge clk);
      S = 1'b1;
      D = 4'h5;
      #2;
      S = 1'b0;
      D = 4'hA;
      @(posedge clk); #1;
      check("sample_at_edge", qout, 4'h2);

      tick(1'b1, 4'hF, 4'hF, "hold_f1");
      tick(1'b1, 4'hF, 4'hF, "hold_f2");
      tick(1'b1, 4'hF, 4'hF, "hold_f3");
      tick(1'b0, 4'hF, 4'h0, "after_hold_wrap");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
